// File: rtl/note_hit_judge.sv
// ---------------------------------------------------------------------------
// note_hit_judge
//
// Scores drum-pad presses against the single falling note row drawn by the
// lane display block. Each pad press is judged as a hit (the lane holds an
// unplayed note while the row is inside the hit window), a wrong press (the
// lane holds no unplayed note, inside the window) or ignored (outside the
// window). Notes still unplayed when the row leaves the window count as a miss.
//
// Optional feature macro: PERFECT_BONUS_EN
//   defined   - hits judged with PERF_TOP <= posicionYS <= PERF_BOT add 20
//               instead of 10 and raise perfect_pulse
//   undefined - every hit adds 10, perfect_pulse is held at 0
//
// Ports
//   clk            in   1        system clock
//   reset          in   1        asynchronous active-high reset, clears all state
//   enable         in   1        row (re)start strobe shared with the display
//   contar         in   1        display step strobe
//   posicionYS     in   10       current row top position
//   cubosHileraReg in   5        lanes holding a note in the current row
//   pads           in   5        raw asynchronous pad levels, bit i = lane i
//   hit_pulse      out  5        one-cycle pulse per lane judged a hit
//   perfect_pulse  out  1        one-cycle pulse for a hit in the perfect zone
//   wrong_pulse    out  1        one-cycle pulse on any wrong press
//   miss_pulse     out  1        one-cycle pulse when unplayed notes leave the window
//   score          out  SCORE_W  accumulated score, saturating
//   combo          out  8        consecutive-hit count, saturating at 255
//   max_combo      out  8        highest combo since reset
//   pending        out  5        lanes of the current row not yet hit
// ---------------------------------------------------------------------------
module note_hit_judge #(
    parameter int PUNTOFINAL = 480,
    parameter int WIN_TOP    = 384,
    parameter int WIN_BOT    = 448,
    parameter int PERF_TOP   = 404,
    parameter int PERF_BOT   = 428,
    parameter int SCORE_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               contar,
    input  logic [9:0]         posicionYS,
    input  logic [4:0]         cubosHileraReg,
    input  logic [4:0]         pads,
    output logic [4:0]         hit_pulse,
    output logic               perfect_pulse,
    output logic               wrong_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo,
    output logic [4:0]         pending
);

    localparam logic [9:0] PUNTOFINAL_L = 10'(PUNTOFINAL);
    localparam logic [9:0] WIN_TOP_L    = 10'(WIN_TOP);
    localparam logic [9:0] WIN_BOT_L    = 10'(WIN_BOT);

    typedef enum logic [1:0] {S_IDLE, S_ABOVE, S_WINDOW, S_BELOW} state_t;

    state_t             state_q, state_d;
    logic [4:0]         pad_s1_q, pad_s2_q, pad_s3_q;
    logic [4:0]         press;
    logic               wrap;
    logic               load_q;
    logic [4:0]         pending_q, pending_d;
    logic [4:0]         hit_pulse_q, hits_d;
    logic               perfect_q, perfect_d;
    logic               wrong_q, wrong_d;
    logic               miss_q, miss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         combo_q, combo_d;
    logic [7:0]         max_combo_q, max_combo_d;

    logic               in_window;
    logic [4:0]         wrongs;
    logic [4:0]         perf_hits;
    logic [2:0]         n_hits, n_perf;
    logic [7:0]         score_add;
    logic [SCORE_W+7:0] score_sum;
    logic [8:0]         combo_sum;

    // Per-lane two-flop synchronizer plus one extra stage for edge detection.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_pad_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pad_s1_q[gi] <= 1'b0;
                    pad_s2_q[gi] <= 1'b0;
                    pad_s3_q[gi] <= 1'b0;
                end else begin
                    pad_s1_q[gi] <= pads[gi];
                    pad_s2_q[gi] <= pad_s1_q[gi];
                    pad_s3_q[gi] <= pad_s2_q[gi];
                end
            end
            assign press[gi] = pad_s2_q[gi] & ~pad_s3_q[gi];
        end
    endgenerate

    assign wrap = contar && (posicionYS == PUNTOFINAL_L);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A row restart (strobe edge or the following load edge)
    // pins the machine to ABOVE so the restart can never look like the row
    // leaving the window.
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (load_q) begin
                state_d = S_ABOVE;
            end
        end else if (enable || wrap || load_q) begin
            state_d = S_ABOVE;
        end else if (posicionYS < WIN_TOP_L) begin
            state_d = S_ABOVE;
        end else if (posicionYS <= WIN_BOT_L) begin
            state_d = S_WINDOW;
        end else begin
            state_d = S_BELOW;
        end
    end

    // FSM: outputs. Presses are judged against the state being entered, so a
    // press on the edge that leaves the window is ignored and the note misses.
    always_comb begin
        in_window = (state_d == S_WINDOW);
        hits_d    = in_window ? (press & pending_q)  : 5'd0;
        wrongs    = in_window ? (press & ~pending_q) : 5'd0;
        wrong_d   = |wrongs;
        miss_d    = (state_q == S_WINDOW) && (state_d == S_BELOW) && (|pending_q);

`ifdef PERFECT_BONUS_EN
        perf_hits = ((posicionYS >= 10'(PERF_TOP)) && (posicionYS <= 10'(PERF_BOT)))
                    ? hits_d : 5'd0;
`else
        perf_hits = 5'd0;
`endif
        perfect_d = |perf_hits;

        if (load_q) begin
            pending_d = cubosHileraReg;
        end else if (miss_d) begin
            pending_d = 5'd0;
        end else begin
            pending_d = pending_q & ~hits_d;
        end

        n_hits = 3'd0;
        n_perf = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_hits = n_hits + {2'b00, hits_d[i]};
            n_perf = n_perf + {2'b00, perf_hits[i]};
        end

        // A perfect hit earns a second helping of 10 on top of the base 10.
        score_add = (8'(n_hits) * 8'd10) + (8'(n_perf) * 8'd10);
        score_sum = {8'd0, score_q} + {{SCORE_W{1'b0}}, score_add};
        if (score_sum[SCORE_W+7:SCORE_W] != 8'd0) begin
            score_d = {SCORE_W{1'b1}};
        end else begin
            score_d = score_sum[SCORE_W-1:0];
        end

        combo_sum = {1'b0, combo_q} + {6'd0, n_hits};
        if (wrong_d || miss_d) begin
            combo_d = 8'd0;
        end else if (combo_sum[8]) begin
            combo_d = 8'hFF;
        end else begin
            combo_d = combo_sum[7:0];
        end

        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q      <= 1'b0;
            pending_q   <= 5'd0;
            hit_pulse_q <= 5'd0;
            perfect_q   <= 1'b0;
            wrong_q     <= 1'b0;
            miss_q      <= 1'b0;
            score_q     <= '0;
            combo_q     <= 8'd0;
            max_combo_q <= 8'd0;
        end else begin
            // The display latches its new lane mask on the strobe edge, so the
            // mask is taken one edge later.
            load_q      <= enable | wrap;
            pending_q   <= pending_d;
            hit_pulse_q <= hits_d;
            perfect_q   <= perfect_d;
            wrong_q     <= wrong_d;
            miss_q      <= miss_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    assign hit_pulse     = hit_pulse_q;
    assign perfect_pulse = perfect_q;
    assign wrong_pulse   = wrong_q;
    assign miss_pulse    = miss_q;
    assign score         = score_q;
    assign combo         = combo_q;
    assign max_combo     = max_combo_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_note_hit_judge.sv
module tb_note_hit_judge;

    localparam int PF = 480;
    localparam int WT = 384;
    localparam int WB = 448;
    localparam int PT = 404;
    localparam int PB = 428;
    localparam int SW = 16;
    localparam int SCORE_MAX = (1 << SW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        contar;
    logic [9:0]  pos;
    logic [4:0]  cubos;
    logic [4:0]  pads;
    logic [4:0]  hit_pulse;
    logic        perfect_pulse;
    logic        wrong_pulse;
    logic        miss_pulse;
    logic [SW-1:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [4:0]  pending;

    always #5 clk = ~clk;

    note_hit_judge #(
        .PUNTOFINAL(PF), .WIN_TOP(WT), .WIN_BOT(WB),
        .PERF_TOP(PT), .PERF_BOT(PB), .SCORE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .contar(contar),
        .posicionYS(pos), .cubosHileraReg(cubos), .pads(pads),
        .hit_pulse(hit_pulse), .perfect_pulse(perfect_pulse),
        .wrong_pulse(wrong_pulse), .miss_pulse(miss_pulse),
        .score(score), .combo(combo), .max_combo(max_combo), .pending(pending)
    );

    int total = 0;
    int bad   = 0;
    bit verbose = 1'b1;

    // Reference model: row position classified into zones; pad presses seen
    // two edges after the pad is first sampled high.
    localparam int Z_IDLE = 0, Z_ABOVE = 1, Z_WIN = 2, Z_BELOW = 3;
    int       m_zone;
    bit       m_reload;
    bit [4:0] m_pend;
    bit [4:0] pad_n1, pad_n2, pad_n3;
    int       e_score, e_combo, e_max;
    bit [4:0] e_hit;
    bit       e_perf, e_wrong, e_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_clear();
        m_zone = Z_IDLE; m_reload = 0; m_pend = 0;
        pad_n1 = 0; pad_n2 = 0; pad_n3 = 0;
        e_score = 0; e_combo = 0; e_max = 0;
        e_hit = 0; e_perf = 0; e_wrong = 0; e_miss = 0;
    endtask

    task automatic model_edge();
        int       zone, nz, nh, add;
        bit       wrap, perf;
        bit [4:0] pr, hits, wr;
        if (reset) begin
            model_clear();
            return;
        end
        wrap = contar && (int'(pos) == PF);
        if (int'(pos) < WT)       zone = Z_ABOVE;
        else if (int'(pos) <= WB) zone = Z_WIN;
        else                      zone = Z_BELOW;
        if (m_zone == Z_IDLE)                  nz = m_reload ? Z_ABOVE : Z_IDLE;
        else if (enable || wrap || m_reload)   nz = Z_ABOVE;
        else                                   nz = zone;

        pr   = pad_n2 & ~pad_n3;
        hits = (nz == Z_WIN) ? (pr & m_pend)  : 5'd0;
        wr   = (nz == Z_WIN) ? (pr & ~m_pend) : 5'd0;
        e_miss = (m_zone == Z_WIN) && (nz == Z_BELOW) && (m_pend != 0);

        nh = $countones(hits);
`ifdef PERFECT_BONUS_EN
        perf = (int'(pos) >= PT) && (int'(pos) <= PB) && (nh > 0);
`else
        perf = 1'b0;
`endif
        add = perf ? 20 * nh : 10 * nh;
        e_score = (e_score + add > SCORE_MAX) ? SCORE_MAX : e_score + add;
        if (wr != 0 || e_miss) e_combo = 0;
        else                   e_combo = (e_combo + nh > 255) ? 255 : e_combo + nh;
        if (e_combo > e_max) e_max = e_combo;

        if (m_reload)    m_pend = cubos;
        else if (e_miss) m_pend = 0;
        else             m_pend = m_pend & ~hits;

        e_hit = hits; e_perf = perf; e_wrong = (wr != 0);
        m_reload = enable || wrap;
        m_zone = nz;
        pad_n3 = pad_n2; pad_n2 = pad_n1; pad_n1 = pads;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("hit_pulse", 32'(hit_pulse), 32'(e_hit));
        check("perfect_pulse", 32'(perfect_pulse), 32'(e_perf));
        check("wrong_pulse", 32'(wrong_pulse), 32'(e_wrong));
        check("miss_pulse", 32'(miss_pulse), 32'(e_miss));
        check("score", 32'(score), 32'(e_score));
        check("combo", 32'(combo), 32'(e_combo));
        check("max_combo", 32'(max_combo), 32'(e_max));
        check("pending", 32'(pending), 32'(m_pend));
        if (verbose && (hit_pulse != 0 || wrong_pulse || miss_pulse))
            $display("t=%0t pos=%0d hit=%b perf=%b wrong=%b miss=%b score=%0d combo=%0d max=%0d",
                     $time, pos, hit_pulse, perfect_pulse, wrong_pulse, miss_pulse,
                     score, combo, max_combo);
    endtask

    task automatic start_row(input logic [4:0] mask);
        enable = 1'b1; cubos = mask; pos = 10'd0; pads = 5'd0;
        step();
        enable = 1'b0;
        step();
    endtask

    task automatic row_hits(input logic [4:0] mask, input logic [4:0] pv);
        start_row(mask);
        pos = 10'd420; pads = pv;
        step();
        pads = 5'd0;
        step();
        step();
    endtask

    int held_hits;
    int ev_score;

    initial begin
        reset = 1'b1; enable = 1'b0; contar = 1'b0;
        pos = 10'd0; cubos = 5'd0; pads = 5'd0;
        model_clear();
        step(); step();
        check("rst_score", 32'(score), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        step();

        // Single hit on lane 0, then miss of lane 2 on 448 -> 449.
        start_row(5'b00101);
        pos = 10'd400; step();
        pads = 5'b00001; step(); step(); step();
        check("tp1_hit", 32'(hit_pulse), 32'b00001);
        check("tp1_score", 32'(score), 32'd10);
        check("tp1_combo", 32'(combo), 32'd1);
        check("tp1_pending", 32'(pending), 32'b00100);
        pads = 5'd0; step();
        pos = 10'd448; step();
        pos = 10'd449; step();
        check("tp2_miss", 32'(miss_pulse), 32'd1);
        check("tp2_combo", 32'(combo), 32'd0);
        check("tp2_pending", 32'(pending), 32'd0);
        check("tp2_score", 32'(score), 32'd10);
        step();
        check("tp2_miss_end", 32'(miss_pulse), 32'd0);

        // Simultaneous hit and wrong press.
        start_row(5'b00001);
        pos = 10'd420; step();
        pads = 5'b00011; step(); step(); step();
        check("tp3_hit", 32'(hit_pulse), 32'b00001);
        check("tp3_wrong", 32'(wrong_pulse), 32'd1);
        check("tp3_combo", 32'(combo), 32'd0);
`ifdef PERFECT_BONUS_EN
        ev_score = 30;
        check("tp3_perfect", 32'(perfect_pulse), 32'd1);
`else
        ev_score = 20;
        check("tp3_perfect", 32'(perfect_pulse), 32'd0);
`endif
        check("tp3_score", 32'(score), 32'(ev_score));
        pads = 5'd0; step(); step();

        // Presses outside the window are ignored; a held pad is judged once.
        start_row(5'b11111);
        pos = 10'd200; pads = 5'b00010; step(); step(); step();
        pads = 5'd0; step();
        pos = 10'd470; pads = 5'b00100; step(); step(); step();
        pads = 5'd0; step();
        check("tp4_score", 32'(score), 32'(ev_score));
        check("tp4_pending", 32'(pending), 32'b11111);
        pos = 10'd420; pads = 5'b01000;
        held_hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (hit_pulse[3]) held_hits++;
        end
        check("tp4_held_single", 32'(held_hits), 32'd1);
        pads = 5'd0; step();
        pos = 10'd449; step(); step();

        // Randomized play against a display-like row generator.
        start_row(5'(($urandom)));
        for (int c = 0; c < 12000; c++) begin
            enable = ($urandom_range(0, 2999) == 0);
            contar = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 31) == 0)
                pads = pads ^ 5'(1 << $urandom_range(0, 4));
            step();
            if (enable) begin
                pos = 10'd0; cubos = 5'($urandom);
            end else if (contar) begin
                if (int'(pos) == PF) begin
                    pos = 10'd0; cubos = 5'($urandom);
                end else begin
                    pos = pos + 10'd1;
                end
            end
        end
        enable = 1'b0; contar = 1'b0; pads = 5'd0;
        step(); step(); step();

        // Build combo 7, then reset asynchronously mid-window.
        row_hits(5'b00000, 5'b00001);
        row_hits(5'b11111, 5'b11111);
        row_hits(5'b00011, 5'b00011);
        check("tp6_combo7", 32'(combo), 32'd7);
        #3 reset = 1'b1;
        #1;
        check("async_hit", 32'(hit_pulse), 32'd0);
        check("async_wrong", 32'(wrong_pulse), 32'd0);
        check("async_miss", 32'(miss_pulse), 32'd0);
        check("async_perfect", 32'(perfect_pulse), 32'd0);
        check("async_score", 32'(score), 32'd0);
        check("async_combo", 32'(combo), 32'd0);
        check("async_max", 32'(max_combo), 32'd0);
        check("async_pending", 32'(pending), 32'd0);
        model_clear();
        step();
        reset = 1'b0;
        step();
        pads = 5'b00001; step();
        pads = 5'd0; step(); step(); step();
        check("idle_ignored_hit", 32'(hit_pulse), 32'd0);
        check("idle_ignored_wrong", 32'(wrong_pulse), 32'd0);

        // Saturation of score and combo.
        verbose = 1'b0;
        for (int r = 0; r < 1400; r++) row_hits(5'b11111, 5'b11111);
        verbose = 1'b1;
        check("sat_score", 32'(score), 32'(SCORE_MAX));
        check("sat_combo", 32'(combo), 32'd255);
        check("sat_max", 32'(max_combo), 32'd255);
        row_hits(5'b00001, 5'b00001);
        check("sat_score_hold", 32'(score), 32'(SCORE_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
